// File: rtl/calc_result_fifo_if.sv
// Handshake bundle between the calc result stage, the result FIFO and its consumer.
// The master side drives results and consumer stall. The slave side is the FIFO.
interface calc_result_fifo_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
);
   logic                     in_valid;
   logic [DATA_W-1:0]        in_data;
   logic                     in_stall;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic                     out_stall;
   logic [$clog2(DEPTH):0]   count;
   logic                     full;
   logic                     empty;
   logic                     overflow;

   modport master (
      output in_valid, in_data, out_stall,
      input  in_stall, out_valid, out_data, count, full, empty, overflow
   );

   modport slave (
      input  in_valid, in_data, out_stall,
      output in_stall, out_valid, out_data, count, full, empty, overflow
   );
endinterface

// File: rtl/calc_result_fifo.sv
// First-word fall-through FIFO buffering calc results, with registered early back-pressure.
// Optional push/drop statistics are enabled by defining CALC_RESULT_FIFO_STATS_EN.
module calc_result_fifo #(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 8,
   parameter int STALL_MARGIN = 2
) (
   input  logic                clk,
   input  logic                rst,
   calc_result_fifo_if.slave   bus
`ifdef CALC_RESULT_FIFO_STATS_EN
   ,
   output logic [15:0]         stat_pushed,
   output logic [15:0]         stat_dropped
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - STALL_MARGIN);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_next;
   logic              stall_q;
   logic              overflow_q;
   logic              pop;
   logic              push;
   logic              drop;

   // A pop frees the slot this cycle, so a full FIFO can still take a word alongside it.
   assign pop  = (cnt != '0) && !bus.out_stall;
   assign push = bus.in_valid && ((cnt != FULL_CNT) || pop);
   assign drop = bus.in_valid && !push;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_next = cnt;
      if (push && !pop)
         cnt_next = cnt + CW'(1);
      else if (pop && !push)
         cnt_next = cnt - CW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         cnt        <= '0;
         stall_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         cnt        <= cnt_next;
         stall_q    <= (cnt_next >= STALL_CNT);
         overflow_q <= overflow_q | drop;
      end
   end

   // NOTE: storage has no reset; the pointers and count alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.in_data;
   end

   assign bus.out_data  = mem[rd_ptr];
   assign bus.out_valid = (cnt != '0);
   assign bus.empty     = (cnt == '0);
   assign bus.full      = (cnt == FULL_CNT);
   assign bus.count     = cnt;
   assign bus.in_stall  = stall_q;
   assign bus.overflow  = overflow_q;

`ifdef CALC_RESULT_FIFO_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_pushed  <= '0;
         stat_dropped <= '0;
      end else begin
         if (push && (stat_pushed != 16'hFFFF))
            stat_pushed <= stat_pushed + 16'd1;
         if (drop && (stat_dropped != 16'hFFFF))
            stat_dropped <= stat_dropped + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_calc_result_fifo.sv
// Bench for calc_result_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_calc_result_fifo;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int MARGIN = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   calc_result_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

`ifdef CALC_RESULT_FIFO_STATS_EN
   logic [15:0] stat_pushed;
   logic [15:0] stat_dropped;
`endif

   calc_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave)
`ifdef CALC_RESULT_FIFO_STATS_EN
      ,
      .stat_pushed  (stat_pushed),
      .stat_dropped (stat_dropped)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: contents as a plain queue, flags from occupancy rules.
   logic [DATA_W-1:0] q[$];
   logic              m_ovf;
   logic              m_stall;
   int                m_pushed;
   int                m_dropped;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_ovf     = 1'b0;
         m_stall   = 1'b0;
         m_pushed  = 0;
         m_dropped = 0;
      end else begin
         automatic bit do_pop  = (q.size() > 0) && !bus.out_stall;
         automatic bit do_push = bus.in_valid && ((q.size() < DEPTH) || do_pop);
         if (do_pop)
            void'(q.pop_front());
         if (do_push) begin
            q.push_back(bus.in_data);
            if (m_pushed < 16'hFFFF) m_pushed++;
         end else if (bus.in_valid) begin
            m_ovf = 1'b1;
            if (m_dropped < 16'hFFFF) m_dropped++;
         end
         m_stall = (q.size() >= DEPTH - MARGIN);
      end
   end

   // Every-cycle comparison on the falling edge, away from the active edge.
   always @(negedge clk) begin
      check("m_count",    64'(bus.count),     64'(q.size()));
      check("m_empty",    64'(bus.empty),     64'(q.size() == 0));
      check("m_full",     64'(bus.full),      64'(q.size() == DEPTH));
      check("m_valid",    64'(bus.out_valid), 64'(q.size() != 0));
      check("m_in_stall", 64'(bus.in_stall),  64'(m_stall));
      check("m_overflow", 64'(bus.overflow),  64'(m_ovf));
      if (q.size() != 0)
         check("m_out_data", 64'(bus.out_data), 64'(q[0]));
`ifdef CALC_RESULT_FIFO_STATS_EN
      check("m_stat_pushed",  64'(stat_pushed),  64'(m_pushed));
      check("m_stat_dropped", 64'(stat_dropped), 64'(m_dropped));
`endif
   end

   // Present inputs for one clock edge, then return just after that edge.
   task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic s);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_stall = s;
      @(posedge clk);
      #1;
   endtask

   logic [DATA_W-1:0] drain_exp [8];
   logic [DATA_W-1:0] got[$];
   int                sent;
   logic              v;
   logic              s;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_stall = 1'b1;
      #1;
      check("rst_count",    64'(bus.count),     64'd0);
      check("rst_empty",    64'(bus.empty),     64'd1);
      check("rst_full",     64'(bus.full),      64'd0);
      check("rst_valid",    64'(bus.out_valid), 64'd0);
      check("rst_in_stall", 64'(bus.in_stall),  64'd0);
      check("rst_overflow", 64'(bus.overflow),  64'd0);
      #11 rst = 1'b0;

      // Fill: the first push lands on the first edge after release.
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, DATA_W'(32'h11 + i), 1'b1);
         check("fill_count",    64'(bus.count),    64'(i + 1));
         check("fill_in_stall", 64'(bus.in_stall), 64'(i + 1 >= 6));
      end
      check("fill_full", 64'(bus.full), 64'd1);

      // Push and pop together while full.
      cyc(1'b1, 32'hAA, 1'b0);
      check("pp_count",    64'(bus.count),    64'd8);
      check("pp_overflow", 64'(bus.overflow), 64'd0);

      // Push while full with no pop is dropped.
      cyc(1'b1, 32'hDEAD, 1'b1);
      check("ovf_flag",  64'(bus.overflow), 64'd1);
      check("ovf_count", 64'(bus.count),    64'd8);
`ifdef CALC_RESULT_FIFO_STATS_EN
      check("ovf_stat_dropped", 64'(stat_dropped), 64'd1);
      check("ovf_stat_pushed",  64'(stat_pushed),  64'd9);
`endif

      drain_exp = '{32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h18, 32'hAA};
      for (int i = 0; i < 8; i++) begin
         check("drain_valid", 64'(bus.out_valid), 64'd1);
         check("drain_data",  64'(bus.out_data),  64'(drain_exp[i]));
         cyc(1'b0, '0, 1'b0);
      end
      check("drain_empty", 64'(bus.empty), 64'd1);

      // Pop requests while empty change nothing.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, '0, 1'b0);
         check("pe_count",    64'(bus.count),    64'd0);
         check("pe_empty",    64'(bus.empty),    64'd1);
         check("pe_overflow", 64'(bus.overflow), 64'd1);
         check("pe_in_stall", 64'(bus.in_stall), 64'd0);
      end

      // Stream 0..19, honouring in_stall, with the consumer stalling every other cycle.
      sent = 0;
      got.delete();
      for (int c = 0; c < 200 && got.size() < 20; c++) begin
         v = (sent < 20) && !bus.in_stall;
         s = c[0];
         if (bus.out_valid && !s)
            got.push_back(bus.out_data);
         cyc(v, DATA_W'(sent), s);
         if (v) sent++;
      end
      check("wrap_n", 64'(got.size()), 64'd20);
      for (int i = 0; i < got.size(); i++)
         check("wrap_data", 64'(got[i]), 64'(i));

      // Reset in the middle of a cycle with 5 words stored.
      for (int i = 0; i < 5; i++)
         cyc(1'b1, DATA_W'(32'h50 + i), 1'b1);
      check("mid_pre_count", 64'(bus.count), 64'd5);
      bus.in_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      check("mid_count",    64'(bus.count),     64'd0);
      check("mid_valid",    64'(bus.out_valid), 64'd0);
      check("mid_overflow", 64'(bus.overflow),  64'd0);
      check("mid_in_stall", 64'(bus.in_stall),  64'd0);
      #9 rst = 1'b0;
      cyc(1'b1, 32'h42, 1'b1);
      check("post_valid", 64'(bus.out_valid), 64'd1);
      check("post_data",  64'(bus.out_data),  64'h42);
      check("post_count", 64'(bus.count),     64'd1);
`ifdef CALC_RESULT_FIFO_STATS_EN
      check("post_stat_pushed", 64'(stat_pushed), 64'd1);
`endif
      cyc(1'b0, '0, 1'b0);
      check("post_empty", 64'(bus.empty), 64'd1);
      cyc(1'b0, '0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/calc_result_fifo.md
CALC_RESULT_FIFO -- requirements
Module: calc_result_fifo

Interface
REQ-001 Parameter DATA_W, default 32, sets the width of each result word; it matches the calc outC width.
REQ-002 Parameter DEPTH, default 8, sets the number of entries; it SHALL be a power of two and at least 4.
REQ-003 Parameter STALL_MARGIN, default 2, sets how many free entries are reserved for results already in flight in the calc pipeline; it SHALL be at least 1 and less than DEPTH.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: a result is present, driven from calc oValid.
REQ-007 Port in_data, input, DATA_W bits: the result word, driven from calc outC.
REQ-008 Port in_stall, output, 1 bit: back-pressure to calc.
REQ-009 Port out_valid, output, 1 bit: the head entry is valid.
REQ-010 Port out_data, output, DATA_W bits: the head entry (first-word fall-through).
REQ-011 Port out_stall, input, 1 bit: the consumer cannot accept a word this cycle.
REQ-012 Port count, output, $clog2(DEPTH)+1 bits: the current occupancy.
REQ-013 Ports full and empty, outputs, 1 bit each: occupancy equals DEPTH, and occupancy equals 0.
REQ-014 Port overflow, output, 1 bit: sticky flag set when a result is dropped.

Function
REQ-015 Pop: the block SHALL pop in a cycle when out_valid=1 and out_stall=0.
REQ-016 Push: the block SHALL accept in_data in a cycle when in_valid=1 and either count<DEPTH or a pop occurs in that same cycle.
REQ-017 Simultaneous push and pop: count SHALL be unchanged and data order SHALL be preserved, including when the FIFO is full.
REQ-018 Push while full with no pop: the word SHALL be dropped, and overflow SHALL be set on the next edge and stay set until rst.
REQ-019 Output timing: out_valid SHALL equal !empty, and out_data SHALL equal the oldest stored word with 0-cycle read latency.
REQ-020 Write-to-read latency: a word pushed into an empty FIFO SHALL appear on out_data with out_valid=1 on the cycle after the push edge.
REQ-021 Stall: in_stall SHALL be registered and SHALL be 1 when the next-state count is at least DEPTH-STALL_MARGIN; otherwise it SHALL be 0.
REQ-022 Pointers: read and write pointers are log2(DEPTH) bits wide and SHALL wrap modulo DEPTH with no extra cycle.
REQ-023 Count: count SHALL never exceed DEPTH or go below 0.
REQ-024 Pop while empty: the request SHALL be ignored; no pointer moves and no flag changes.
REQ-025 Invalid data: when out_valid=0, out_data is don't-care, and bench checks SHALL NOT depend on it.

Reset
REQ-026 Assertion: while rst=1, the block SHALL asynchronously clear pointers and count to 0, set empty=1, and force full=0, out_valid=0, in_stall=0 and overflow=0.
REQ-027 Storage: array contents SHALL NOT be reset.
REQ-028 Reset mid-operation: all buffered words SHALL be discarded, and after release no stale word SHALL appear on out_valid.
REQ-029 Release: the first push SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro CALC_RESULT_FIFO_STATS_EN: when defined, the block SHALL add two outputs:
- stat_pushed, 16 bits: increments on each accepted push.
- stat_dropped, 16 bits: increments on each dropped word.
REQ-031 The two counters SHALL saturate at 16'hFFFF, and both SHALL clear on rst.
REQ-032 When CALC_RESULT_FIFO_STATS_EN is not defined, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Fill and drain: DEPTH=8, push 0x11..0x18 with out_stall=1, then release.
- count reaches 8 and full=1.
- in_stall=1 from the cycle after the 6th push.
- Outputs 0x11..0x18 in order, then empty=1.
REQ-034 Overflow: with the FIFO full and out_stall=1, push 0xDEAD.
- overflow=1 and count stays 8.
- 0xDEAD is never output.
- stat_dropped=1 when stats are enabled.
REQ-035 Simultaneous push and pop at full: push 0xAA while popping the head.
- count stays 8 and overflow stays 0.
- 0xAA is output after the 7 older words.
REQ-036 Wrap-around: stream 20 words 0..19 with out_stall=0 on alternate cycles.
- Output sequence is exactly 0..19.
- Pointers wrap twice with no loss.
REQ-037 Reset mid-operation: with 5 words stored, pulse rst for 1 cycle mid-clock.
- Immediately: count=0, out_valid=0, overflow=0.
- The next push of 0x42 is output next.
REQ-038 Pop while empty: hold out_stall=0 with in_valid=0 for 4 cycles.
- count stays 0 and empty=1.
- No flags change.
